vga_rom_arbiter: RTL and testbench
==================================

Name: vga_rom_arbiter

Overview:
- Shares one single-port sprite/background image ROM between up to N_REQ draw stages of the VGA pipeline (duck, dog, crosshair, HUD).
- Each draw stage issues pixel-fetch requests with a ROM address.
- The arbiter grants ROM cycles round-robin with a bounded burst per owner, drives the ROM, and returns data tagged with the requester ID after the fixed ROM latency.
- It sits between the draw_* stages and the shared template_rom instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 17, ROM address width
DATA_WIDTH, 12, ROM data width (RGB444)
ROM_LATENCY, 1, clock edges from rom_addr/rom_en sampled by ROM to valid rom_dout (1..4)
MAX_BURST, 8, maximum consecutive grants to one owner while others wait (1..255)

Ports:
clk  in  1  system pixel clock
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester fetch request, level
addr  in  N_REQ*ADDR_WIDTH  per-requester address; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
gnt  out  N_REQ  one-hot grant; high for the cycle in which that requester's address is on rom_addr
rom_addr  out  ADDR_WIDTH  address to shared ROM
rom_en  out  1  ROM read enable
rom_dout  in  DATA_WIDTH  ROM read data
rd_valid  out  1  returned data valid
rd_id  out  $clog2(N_REQ) (min 1)  requester index owning rd_data
rd_data  out  DATA_WIDTH  returned ROM data, registered

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_id=0, rd_data=0, burst_cnt=0. The round-robin pointer is set to "last owner = N_REQ-1", so requester 0 wins first. In-flight reads are discarded and never return.
- Arbitration is evaluated every cycle on current req/addr; gnt, rom_addr and rom_en are registered at the next edge.
- States: IDLE (no owner) and OWN (owner k).
- IDLE:
  - If any req is high, grant the first requester after the last owner in circular order. Enter OWN with burst_cnt=1.
  - Otherwise gnt=0 and rom_en=0; rom_addr holds its last value; the pointer holds.
- OWN(k), owner's req still high and burst_cnt<MAX_BURST: re-grant k and increment burst_cnt.
- OWN(k), burst_cnt==MAX_BURST:
  - Rotate to the next requesting index after k, with burst_cnt=1.
  - If k is the only requester, re-grant k with burst_cnt reset to 1. No idle bubble.
- OWN(k), owner's req low: rotate in the same cycle to the next requester after k. If none is requesting, go to IDLE with gnt=0 and the last owner recorded as k.
- A registered grant always has gnt[w]=1, rom_en=1 and rom_addr=addr[w] sampled on the same edge. Exactly zero or one gnt bit is high.
- Requesters keep req/addr stable until they see gnt. A new address may be presented the cycle after gnt. Back-to-back grants are allowed every cycle (full throughput).
- Return path: a tag pipeline of depth ROM_LATENCY carries {valid, id} from each grant. rd_data<=rom_dout, rd_id and rd_valid are registered one edge after the ROM output is valid.
- Total latency: grant edge E → rd_valid high after edge E+ROM_LATENCY+1. Order is preserved.
- rd_valid low: rd_data and rd_id hold their previous values.
- Simultaneous new req from all N_REQ with no owner: the lowest index after the last owner wins.
- req dropped on the same edge as the grant: the grant still issues and data still returns. Requesters must tolerate this.

Test Plan:
- Reset then req=4'b0001, addr0=0x00010 held 3 cycles → gnt=0001 on 3 consecutive cycles, rom_addr=0x00010, rd_valid high 2 cycles after each grant (ROM_LATENCY=1) with rd_id=0 and rd_data=ROM[0x10].
- All four req high continuously, MAX_BURST=8 → gnt sequence 8×0001, 8×0010, 8×0100, 8×1000, then repeats. rd_id stream matches the gnt sequence delayed by 2 cycles. No idle cycles.
- Owner 1 drops req after 3 grants while req2 is high → 3×0010 then 0100 on the next cycle, burst_cnt restarts at 1.
- Only requester 3 active for 20 cycles, MAX_BURST=8 → gnt=1000 every cycle (re-grant on burst expiry, no gap). All 20 reads return with rd_id=3.
- rst pulled low for 1 cycle, asynchronously, while 2 reads are in flight → gnt, rom_en and rd_valid go to 0 immediately. No rd_valid for the aborted reads. After release, requester 0 has priority.
- ROM_LATENCY=3, alternating req0/req1 with MAX_BURST=1 → gnt alternates every cycle, rd_valid asserted 4 cycles after each grant, rd_id alternates 0,1,0,1.

Source files
------------

// File: rtl/vga_rom_arbiter.sv
// vga_rom_arbiter
// Shares one single-port image ROM between the draw stages of the VGA
// pipeline (duck, dog, crosshair, HUD). Requesters are served round-robin,
// and one owner may hold the ROM for a bounded burst while others wait.
// Grants, the ROM address and the ROM enable are registered. Read data comes
// back registered and tagged with the requester index, in grant order.

module vga_rom_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 12,
  parameter int ROM_LATENCY = 1,
  parameter int MAX_BURST   = 8,
  localparam int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  output logic [N_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  output logic                        rom_en,
  input  logic [DATA_WIDTH-1:0]       rom_dout,
  output logic                        rd_valid,
  output logic [ID_WIDTH-1:0]         rd_id,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  // Arbiter states: nobody owns the ROM, or one requester owns it.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // After reset the last owner is the highest index, so requester 0 wins first.
  localparam logic [ID_WIDTH-1:0] OWNER_RESET = ID_WIDTH'(N_REQ - 1);
  localparam logic [7:0]          BURST_LIMIT = 8'(MAX_BURST);

  // Arbitration state.
  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [ID_WIDTH-1:0] owner;
  logic [7:0]          burst_cnt;
  logic [7:0]          burst_next;

  // Result of the circular search for the next requester after the owner.
  logic                nxt_found;
  logic [ID_WIDTH-1:0] nxt_idx;

  // Decision for the coming edge.
  logic                grant;
  logic [ID_WIDTH-1:0] win;
  logic [N_REQ-1:0]    gnt_next;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Requester index of the grant currently on rom_addr.
  logic [ID_WIDTH-1:0] gnt_id;

  // Tag pipeline following the ROM latency.
  logic [ROM_LATENCY-1:0]               tag_v;
  logic [ROM_LATENCY-1:0][ID_WIDTH-1:0] tag_id;

  // Circular search starting after the owner (the owner itself comes last).
  // Scanning from the far end downward leaves the nearest requester in
  // nxt_idx. Including the owner lets a sole requester be re-granted on
  // burst expiry without an idle bubble.
  always_comb begin
    int idx;
    nxt_found = 1'b0;
    nxt_idx   = owner;
    idx       = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(owner) + i) % N_REQ;
      if (req[idx]) begin
        nxt_found = 1'b1;
        nxt_idx   = ID_WIDTH'(idx);
      end
    end
  end

  // Grant decision: keep the owner while it requests and its burst lasts,
  // otherwise rotate to the next requester or fall back to idle.
  always_comb begin
    grant      = 1'b0;
    win        = owner;
    burst_next = burst_cnt;
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (nxt_found) begin
          grant      = 1'b1;
          win        = nxt_idx;
          burst_next = 8'd1;
          state_next = ST_OWN;
        end else begin
          burst_next = 8'd0;
        end
      end
      default: begin
        if (req[owner] && (burst_cnt < BURST_LIMIT)) begin
          grant      = 1'b1;
          win        = owner;
          burst_next = burst_cnt + 8'd1;
          state_next = ST_OWN;
        end else if (nxt_found) begin
          grant      = 1'b1;
          win        = nxt_idx;
          burst_next = 8'd1;
          state_next = ST_OWN;
        end else begin
          burst_next = 8'd0;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // One-hot grant vector and the winner's address.
  always_comb begin
    gnt_next = N_REQ'(1) << win;
    win_addr = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Register the arbitration state and the ROM-side outputs. In idle the
  // owner register keeps the last owner, and rom_addr keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= OWNER_RESET;
      burst_cnt <= 8'd0;
      gnt       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      gnt_id    <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      gnt       <= grant ? gnt_next : '0;
      rom_en    <= grant;
      if (grant) begin
        owner    <= win;
        rom_addr <= win_addr;
        gnt_id   <= win;
      end
    end
  end

  // Carry {valid, id} alongside the ROM access so each returned word keeps
  // its owner. Reset empties the pipe, so aborted reads never return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= rom_en;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Capture ROM data one edge after it becomes valid. The data and id hold
  // their values while nothing returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= tag_v[ROM_LATENCY-1];
      if (tag_v[ROM_LATENCY-1]) begin
        rd_id   <= tag_id[ROM_LATENCY-1];
        rd_data <= rom_dout;
      end
    end
  end

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// tb_vga_rom_arbiter
// Directed bench for vga_rom_arbiter. Two instances are used: one with the
// default ROM latency and burst length, and one with ROM_LATENCY=3 and
// MAX_BURST=1. Each instance has its own synchronous ROM model.

module tb_vga_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 17;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: ROM_LATENCY=1, MAX_BURST=8
  logic [NR-1:0]    req_a = '0;
  logic [AW-1:0]    a [NR];
  logic [NR*AW-1:0] addr_a;
  logic [NR-1:0]    gnt_a;
  logic [AW-1:0]    rom_addr_a;
  logic             rom_en_a;
  logic [DW-1:0]    rom_dout_a;
  logic             rd_valid_a;
  logic [1:0]       rd_id_a;
  logic [DW-1:0]    rd_data_a;

  // Instance B: ROM_LATENCY=3, MAX_BURST=1
  logic [NR-1:0]    req_b = '0;
  logic [AW-1:0]    b [NR];
  logic [NR*AW-1:0] addr_b;
  logic [NR-1:0]    gnt_b;
  logic [AW-1:0]    rom_addr_b;
  logic             rom_en_b;
  logic [DW-1:0]    rom_dout_b;
  logic             rd_valid_b;
  logic [1:0]       rd_id_b;
  logic [DW-1:0]    rd_data_b;

  int total = 0;
  int bad   = 0;

  // Clock generator.
  always #5 clk = ~clk;

  assign addr_a = {a[3], a[2], a[1], a[0]};
  assign addr_b = {b[3], b[2], b[1], b[0]};

  // ROM contents as a function of address.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] x);
    return x[11:0] ^ {x[16:13], 8'h5A};
  endfunction

  // Synchronous ROM models: one register for A, three for B.
  logic [DW-1:0] rom_a_q;
  logic [DW-1:0] rom_b_q [3];
  always @(posedge clk) begin
    rom_a_q    <= rom_f(rom_addr_a);
    rom_b_q[0] <= rom_f(rom_addr_b);
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
  end
  assign rom_dout_a = rom_a_q;
  assign rom_dout_b = rom_b_q[2];

  vga_rom_arbiter #(
    .N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1), .MAX_BURST(8)
  ) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .addr(addr_a), .gnt(gnt_a),
    .rom_addr(rom_addr_a), .rom_en(rom_en_a), .rom_dout(rom_dout_a),
    .rd_valid(rd_valid_a), .rd_id(rd_id_a), .rd_data(rd_data_a)
  );

  vga_rom_arbiter #(
    .N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(3), .MAX_BURST(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .gnt(gnt_b),
    .rom_addr(rom_addr_b), .rom_en(rom_en_b), .rom_dout(rom_dout_b),
    .rd_valid(rd_valid_b), .rd_id(rd_id_b), .rd_data(rd_data_b)
  );

  // Synchronous-style reset pulse leaving the bench just after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset values, visible before any clock edge.
  task automatic test_reset();
    #2;
    rst = 1'b0;
    #1;
    total++; if (gnt_a !== 4'b0)      begin bad++; $display("[TB] FAIL reset gnt got=%b want=0000", gnt_a); end
    total++; if (rom_en_a !== 1'b0)   begin bad++; $display("[TB] FAIL reset rom_en got=%b want=0", rom_en_a); end
    total++; if (rom_addr_a !== '0)   begin bad++; $display("[TB] FAIL reset rom_addr got=%h want=0", rom_addr_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL reset rd_valid got=%b want=0", rd_valid_a); end
    total++; if (rd_id_a !== 2'd0)    begin bad++; $display("[TB] FAIL reset rd_id got=%0d want=0", rd_id_a); end
    total++; if (rd_data_a !== '0)    begin bad++; $display("[TB] FAIL reset rd_data got=%h want=0", rd_data_a); end
    total++; if (gnt_b !== 4'b0)      begin bad++; $display("[TB] FAIL reset gnt_b got=%b want=0000", gnt_b); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (gnt_a !== 4'b0)      begin bad++; $display("[TB] FAIL reset idle gnt got=%b want=0000", gnt_a); end
    total++; if (rom_en_a !== 1'b0)   begin bad++; $display("[TB] FAIL reset idle rom_en got=%b want=0", rom_en_a); end
  endtask

  // Single requester 0 held for three cycles.
  task automatic test_single();
    int gseq [8];
    int g, r;
    logic [3:0] eg;
    for (int i = 0; i < 8; i++) gseq[i] = (i >= 1 && i <= 3) ? 0 : -1;
    req_a = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      g  = gseq[c];
      r  = (c >= 3) ? gseq[c-2] : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      total++; if (gnt_a !== eg)             begin bad++; $display("[TB] FAIL single gnt c=%0d got=%b want=%b", c, gnt_a, eg); end
      total++; if (rom_en_a !== (g >= 0))    begin bad++; $display("[TB] FAIL single rom_en c=%0d got=%b want=%b", c, rom_en_a, (g >= 0)); end
      total++; if (rom_addr_a !== 17'h00010) begin bad++; $display("[TB] FAIL single rom_addr c=%0d got=%h want=00010", c, rom_addr_a); end
      total++; if (rd_valid_a !== (r >= 0))  begin bad++; $display("[TB] FAIL single rd_valid c=%0d got=%b want=%b", c, rd_valid_a, (r >= 0)); end
      if (r >= 0) begin
        total++; if (rd_id_a !== 2'(r))          begin bad++; $display("[TB] FAIL single rd_id c=%0d got=%0d want=%0d", c, rd_id_a, r); end
        total++; if (rd_data_a !== rom_f(a[r]))  begin bad++; $display("[TB] FAIL single rd_data c=%0d got=%h want=%h", c, rd_data_a, rom_f(a[r])); end
      end
      if (c == 3) req_a = 4'b0000;
    end
  endtask

  // All four requesting: bursts of eight in order 0,1,2,3,0 without gaps.
  task automatic test_all_four();
    int gseq [48];
    int g, r;
    logic [3:0] eg;
    for (int i = 0; i < 48; i++) gseq[i] = (i >= 1 && i <= 40) ? ((i - 1) / 8) % 4 : -1;
    req_a = 4'b1111;
    for (int c = 1; c <= 43; c++) begin
      @(posedge clk);
      #1;
      g  = gseq[c];
      r  = (c >= 3) ? gseq[c-2] : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      total++; if (gnt_a !== eg)            begin bad++; $display("[TB] FAIL all4 gnt c=%0d got=%b want=%b", c, gnt_a, eg); end
      total++; if (rom_en_a !== (g >= 0))   begin bad++; $display("[TB] FAIL all4 rom_en c=%0d got=%b want=%b", c, rom_en_a, (g >= 0)); end
      if (g >= 0) begin
        total++; if (rom_addr_a !== a[g])   begin bad++; $display("[TB] FAIL all4 rom_addr c=%0d got=%h want=%h", c, rom_addr_a, a[g]); end
      end
      total++; if (rd_valid_a !== (r >= 0)) begin bad++; $display("[TB] FAIL all4 rd_valid c=%0d got=%b want=%b", c, rd_valid_a, (r >= 0)); end
      if (r >= 0) begin
        total++; if (rd_id_a !== 2'(r))         begin bad++; $display("[TB] FAIL all4 rd_id c=%0d got=%0d want=%0d", c, rd_id_a, r); end
        total++; if (rd_data_a !== rom_f(a[r])) begin bad++; $display("[TB] FAIL all4 rd_data c=%0d got=%h want=%h", c, rd_data_a, rom_f(a[r])); end
      end
      if (c == 40) req_a = 4'b0000;
    end
  endtask

  // Owner 1 drops out after three grants; requester 2 then gets a fresh
  // burst of eight before requester 3 takes over.
  task automatic test_owner_drop();
    int gseq [20];
    int g, r;
    logic [3:0] eg;
    for (int i = 0; i < 20; i++) begin
      if (i >= 1 && i <= 3)        gseq[i] = 1;
      else if (i >= 4 && i <= 11)  gseq[i] = 2;
      else if (i >= 12 && i <= 13) gseq[i] = 3;
      else                         gseq[i] = -1;
    end
    req_a = 4'b0110;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      g  = gseq[c];
      r  = (c >= 3) ? gseq[c-2] : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      total++; if (gnt_a !== eg)            begin bad++; $display("[TB] FAIL drop gnt c=%0d got=%b want=%b", c, gnt_a, eg); end
      total++; if (rom_en_a !== (g >= 0))   begin bad++; $display("[TB] FAIL drop rom_en c=%0d got=%b want=%b", c, rom_en_a, (g >= 0)); end
      total++; if (rd_valid_a !== (r >= 0)) begin bad++; $display("[TB] FAIL drop rd_valid c=%0d got=%b want=%b", c, rd_valid_a, (r >= 0)); end
      if (r >= 0) begin
        total++; if (rd_id_a !== 2'(r))         begin bad++; $display("[TB] FAIL drop rd_id c=%0d got=%0d want=%0d", c, rd_id_a, r); end
        total++; if (rd_data_a !== rom_f(a[r])) begin bad++; $display("[TB] FAIL drop rd_data c=%0d got=%h want=%h", c, rd_data_a, rom_f(a[r])); end
      end
      if (c == 3)  req_a = 4'b0100;
      if (c == 4)  req_a = 4'b1100;
      if (c == 13) req_a = 4'b0000;
    end
  endtask

  // Only requester 3 for 20 cycles: re-granted every cycle across burst ends.
  task automatic test_only_three();
    int gseq [26];
    int g, r;
    int returns;
    logic [3:0] eg;
    returns = 0;
    for (int i = 0; i < 26; i++) gseq[i] = (i >= 1 && i <= 20) ? 3 : -1;
    req_a = 4'b1000;
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk);
      #1;
      g  = gseq[c];
      r  = (c >= 3) ? gseq[c-2] : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      total++; if (gnt_a !== eg)            begin bad++; $display("[TB] FAIL only3 gnt c=%0d got=%b want=%b", c, gnt_a, eg); end
      total++; if (rd_valid_a !== (r >= 0)) begin bad++; $display("[TB] FAIL only3 rd_valid c=%0d got=%b want=%b", c, rd_valid_a, (r >= 0)); end
      if (rd_valid_a === 1'b1) returns++;
      if (r >= 0) begin
        total++; if (rd_id_a !== 2'(r)) begin bad++; $display("[TB] FAIL only3 rd_id c=%0d got=%0d want=%0d", c, rd_id_a, r); end
      end
      if (c == 20) req_a = 4'b0000;
    end
    total++; if (returns != 20) begin bad++; $display("[TB] FAIL only3 returns got=%0d want=20", returns); end
  endtask

  // Asynchronous reset with reads in flight: everything clears at once, the
  // aborted reads never return, and requester 0 wins afterwards.
  task automatic test_async_reset();
    req_a = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      total++; if (gnt_a !== 4'b0010) begin bad++; $display("[TB] FAIL areset pre gnt c=%0d got=%b want=0010", c, gnt_a); end
    end
    total++; if (rd_valid_a !== 1'b1) begin bad++; $display("[TB] FAIL areset pre rd_valid got=%b want=1", rd_valid_a); end
    total++; if (rd_id_a !== 2'd1)    begin bad++; $display("[TB] FAIL areset pre rd_id got=%0d want=1", rd_id_a); end
    #2;
    rst   = 1'b0;
    req_a = 4'b0011;
    #1;
    total++; if (gnt_a !== 4'b0)      begin bad++; $display("[TB] FAIL areset gnt got=%b want=0000", gnt_a); end
    total++; if (rom_en_a !== 1'b0)   begin bad++; $display("[TB] FAIL areset rom_en got=%b want=0", rom_en_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL areset rd_valid got=%b want=0", rd_valid_a); end
    @(posedge clk);
    #1;
    total++; if (gnt_a !== 4'b0)      begin bad++; $display("[TB] FAIL areset hold gnt got=%b want=0000", gnt_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL areset hold rd_valid got=%b want=0", rd_valid_a); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 5; c <= 7; c++) begin
      @(posedge clk);
      #1;
      total++; if (gnt_a !== 4'b0001) begin bad++; $display("[TB] FAIL areset post gnt c=%0d got=%b want=0001", c, gnt_a); end
      total++; if (rd_valid_a !== (c == 7)) begin bad++; $display("[TB] FAIL areset post rd_valid c=%0d got=%b want=%b", c, rd_valid_a, (c == 7)); end
      if (c == 7) begin
        total++; if (rd_id_a !== 2'd0)          begin bad++; $display("[TB] FAIL areset post rd_id got=%0d want=0", rd_id_a); end
        total++; if (rd_data_a !== rom_f(a[0])) begin bad++; $display("[TB] FAIL areset post rd_data got=%h want=%h", rd_data_a, rom_f(a[0])); end
      end
    end
    req_a = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Instance B: alternating requesters with one-grant bursts and a
  // three-cycle ROM; data returns four cycles after each grant.
  task automatic test_latency3();
    int gseq [20];
    int g, r;
    logic [3:0] eg;
    for (int i = 0; i < 20; i++) gseq[i] = (i >= 1 && i <= 12) ? (i - 1) % 2 : -1;
    req_b = 4'b0011;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      g  = gseq[c];
      r  = (c >= 5) ? gseq[c-4] : -1;
      eg = (g >= 0) ? 4'(1 << g) : 4'b0;
      total++; if (gnt_b !== eg)            begin bad++; $display("[TB] FAIL lat3 gnt c=%0d got=%b want=%b", c, gnt_b, eg); end
      total++; if (rom_en_b !== (g >= 0))   begin bad++; $display("[TB] FAIL lat3 rom_en c=%0d got=%b want=%b", c, rom_en_b, (g >= 0)); end
      total++; if (rd_valid_b !== (r >= 0)) begin bad++; $display("[TB] FAIL lat3 rd_valid c=%0d got=%b want=%b", c, rd_valid_b, (r >= 0)); end
      if (r >= 0) begin
        total++; if (rd_id_b !== 2'(r))         begin bad++; $display("[TB] FAIL lat3 rd_id c=%0d got=%0d want=%0d", c, rd_id_b, r); end
        total++; if (rd_data_b !== rom_f(b[r])) begin bad++; $display("[TB] FAIL lat3 rd_data c=%0d got=%h want=%h", c, rd_data_b, rom_f(b[r])); end
      end
      if (c == 12) req_b = 4'b0000;
    end
  endtask

  // Test sequence.
  initial begin
    a[0] = 17'h00010;
    a[1] = 17'h0ABC1;
    a[2] = 17'h12342;
    a[3] = 17'h1F0F3;
    b[0] = 17'h03000;
    b[1] = 17'h05A71;
    b[2] = 17'h00000;
    b[3] = 17'h00000;
    test_reset();
    test_single();
    do_reset();
    test_all_four();
    test_owner_drop();
    test_only_three();
    test_async_reset();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
